// File: rtl/wb_drain_ctrl_pkg.sv
// Shared definitions for the writeback store-drain controller.
// Holds the FIFO entry field layout, store-size encodings and FSM states.
package wb_drain_ctrl_pkg;

    // FIFO entry layout: {data[63:0], addr[31:0], size[1:0]}
    localparam int ENTRY_W   = 98;
    localparam int DATA_LO   = 34;
    localparam int ADDR_LO   = 2;
    localparam int SIZE_LO   = 0;
    localparam int BUS_BYTES = 4;

    // Store size encodings (bytes = 1 << size)
    localparam logic [1:0] SZ_1B = 2'd0;
    localparam logic [1:0] SZ_2B = 2'd1;
    localparam logic [1:0] SZ_4B = 2'd2;
    localparam logic [1:0] SZ_8B = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/wb_drain_ctrl_beat.sv
// wb_beat_gen: combinational beat generator for one store entry.
// Given the store address, size, data and a beat index, produces the
// word-aligned bus address, lane-aligned write data (disabled lanes zero),
// byte enables, and whether this index is the final beat of the store.
// Ports:
//   addr       in  32  store byte address
//   size       in  2   size encoding (bytes = 1 << size)
//   data       in  64  store data, low bytes meaningful
//   beat_idx   in  2   beat number 0..2
//   beat_addr  out 32  {addr[31:2] + beat_idx, 2'b00}
//   beat_wdata out 32  slice of the shifted data window
//   beat_be    out 4   lane enables
//   last_beat  out 1   beat_idx is the final beat
module wb_beat_gen
    import wb_drain_ctrl_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic [63:0] data,
    input  logic [1:0]  beat_idx,
    output logic [31:0] beat_addr,
    output logic [31:0] beat_wdata,
    output logic [3:0]  beat_be,
    output logic        last_beat
);

    logic [1:0]  off;
    logic [3:0]  n_bytes;
    logic [3:0]  lo;
    logic [3:0]  hi;
    logic [3:0]  span_m1;
    logic [3:0]  pos;
    logic [63:0] data_m;
    logic [95:0] window;

    always_comb begin
        off     = addr[1:0];
        n_bytes = 4'd1;
        data_m  = '0;
        // Bytes beyond the store size are zeroed so disabled lanes read 0.
        case (size)
            SZ_1B: begin n_bytes = 4'd1; data_m = {56'b0, data[7:0]};  end
            SZ_2B: begin n_bytes = 4'd2; data_m = {48'b0, data[15:0]}; end
            SZ_4B: begin n_bytes = 4'd4; data_m = {32'b0, data[31:0]}; end
            default: begin n_bytes = 4'd8; data_m = data;              end
        endcase

        lo      = {2'b00, off};
        hi      = lo + n_bytes - 4'd1;
        span_m1 = lo + n_bytes - 4'd1;
        window  = {32'b0, data_m} << {off, 3'b000};

        case (beat_idx)
            2'd0:    beat_wdata = window[31:0];
            2'd1:    beat_wdata = window[63:32];
            default: beat_wdata = window[95:64];
        endcase

        beat_be = '0;
        for (int j = 0; j < BUS_BYTES; j++) begin
            pos        = {beat_idx, 2'b00} + 4'(j);
            beat_be[j] = (pos >= lo) && (pos <= hi);
        end

        // Word address wraps within 30 bits; no carry into anything.
        beat_addr = {addr[31:2] + {28'b0, beat_idx}, 2'b00};
        // Beats = ceil(span/4), so last index = (span-1)/4.
        last_beat = (beat_idx == span_m1[3:2]);
    end

endmodule

// File: rtl/wb_drain_ctrl.sv
// wb_drain_ctrl: drains the writeback store FIFO into aligned 32-bit write
// beats on the data-memory port, one entry at a time, req/ack per beat.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   fifo_empty       in   FIFO has no valid entry
//   fifo_rd_data     in   head entry {data, addr, size}
//   fifo_rd          out  pop pulse (combinational)
//   drain_en         in   allow popping new entries
//   mem_req          out  beat valid (registered, held until ack)
//   mem_addr         out  word-aligned beat address
//   mem_wdata        out  beat data, disabled lanes zero
//   mem_be           out  byte-lane enables
//   mem_ack          in   beat accepted this edge
//   drain_idle       out  idle with nothing left to drain
module wb_drain_ctrl
    import wb_drain_ctrl_pkg::*;
#(
    parameter int DATA_W = 98,
    parameter int ADDR_W = 32,
    parameter int BUS_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic [DATA_W-1:0]    fifo_rd_data,
    output logic                 fifo_rd,
    input  logic                 drain_en,
    output logic                 mem_req,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [BUS_W-1:0]     mem_wdata,
    output logic [BUS_W/8-1:0]   mem_be,
    input  logic                 mem_ack,
    output logic                 drain_idle
);

    state_t      state_q, state_d;
    logic [1:0]  beat_q;
    logic [31:0] ent_addr;
    logic [1:0]  ent_size;
    logic [63:0] ent_data;
    logic        last_q;

    logic        pop, adv, stop;

    logic [31:0] gen_addr_in;
    logic [1:0]  gen_size_in;
    logic [63:0] gen_data_in;
    logic [1:0]  gen_idx_in;
    logic [31:0] gen_addr, gen_wdata;
    logic [3:0]  gen_be;
    logic        gen_last;

    // On a pop the first beat is built straight from the FIFO head so it can
    // be registered in the same edge the entry is latched; otherwise the
    // generator looks one beat ahead on the latched entry.
    always_comb begin
        if (pop) begin
            gen_addr_in = fifo_rd_data[ADDR_LO +: 32];
            gen_size_in = fifo_rd_data[SIZE_LO +: 2];
            gen_data_in = fifo_rd_data[DATA_LO +: 64];
            gen_idx_in  = 2'd0;
        end else begin
            gen_addr_in = ent_addr;
            gen_size_in = ent_size;
            gen_data_in = ent_data;
            gen_idx_in  = beat_q + 2'd1;
        end
    end

    wb_beat_gen u_beat_gen (
        .addr       (gen_addr_in),
        .size       (gen_size_in),
        .data       (gen_data_in),
        .beat_idx   (gen_idx_in),
        .beat_addr  (gen_addr),
        .beat_wdata (gen_wdata),
        .beat_be    (gen_be),
        .last_beat  (gen_last)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        adv     = 1'b0;
        stop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && drain_en) begin
                    pop     = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_req && mem_ack) begin
                    if (!last_q) begin
                        adv = 1'b1;
                    end else if (!fifo_empty && drain_en) begin
                        pop = 1'b1;   // chain next entry, stay BUSY
                    end else begin
                        stop    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // The pop is suppressed while reset is held so nothing is consumed.
        if (rst) begin
            pop  = 1'b0;
            adv  = 1'b0;
            stop = 1'b0;
        end
        fifo_rd    = pop;
        drain_idle = (state_q == ST_IDLE) && fifo_empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            beat_q    <= '0;
            ent_addr  <= '0;
            ent_size  <= '0;
            ent_data  <= '0;
            last_q    <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                ent_addr  <= fifo_rd_data[ADDR_LO +: 32];
                ent_size  <= fifo_rd_data[SIZE_LO +: 2];
                ent_data  <= fifo_rd_data[DATA_LO +: 64];
                beat_q    <= 2'd0;
                last_q    <= gen_last;
                mem_req   <= 1'b1;
                mem_addr  <= gen_addr;
                mem_wdata <= gen_wdata;
                mem_be    <= gen_be;
            end else if (adv) begin
                beat_q    <= beat_q + 2'd1;
                last_q    <= gen_last;
                mem_addr  <= gen_addr;
                mem_wdata <= gen_wdata;
                mem_be    <= gen_be;
            end else if (stop) begin
                beat_q    <= 2'd0;
                last_q    <= 1'b0;
                mem_req   <= 1'b0;
                mem_addr  <= '0;
                mem_wdata <= '0;
                mem_be    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wb_drain_ctrl.sv
// Self-checking bench for wb_drain_ctrl: FIFO model, ack driver, and a
// scoreboard of expected beats compared as each beat is accepted.
module tb_wb_drain_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty;
    logic [97:0] fifo_rd_data;
    logic        fifo_rd;
    logic        drain_en;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        drain_idle;

    wb_drain_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd      (fifo_rd),
        .drain_en     (drain_en),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_ack      (mem_ack),
        .drain_idle   (drain_idle)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } beat_t;

    beat_t       sb[$];
    logic [97:0] fq[$];

    int    checks, errors;
    int    stall_n, wait_cnt;
    int    pops, accepts, b2b;
    bit    force_ack, pop_pend, prev_pop, prev_stall;
    bit    rst_nx, drain_nx;
    beat_t held;

    task automatic push(input logic [31:0] a, input logic [1:0] sz, input logic [63:0] d);
        fq.push_back({d, a, sz});
    endtask

    task automatic exp_beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        beat_t b;
        b.a = a; b.d = d; b.be = be;
        sb.push_back(b);
    endtask

    // Byte-by-byte reference: each store byte lands in the word holding its
    // byte address, at lane addr[1:0].
    task automatic model_push(input logic [31:0] a, input logic [1:0] sz, input logic [63:0] d);
        beat_t       bt[3];
        int          n, nb;
        logic [31:0] b, kk;
        n  = 1 << sz;
        nb = (int'(a[1:0]) + n + 3) / 4;
        for (int k = 0; k < 3; k++) begin
            bt[k].a  = ((a >> 2) + 32'(k)) << 2;
            bt[k].d  = '0;
            bt[k].be = '0;
        end
        for (int i = 0; i < n; i++) begin
            b  = a + 32'(i);
            kk = ((b >> 2) - (a >> 2)) & 32'h3FFF_FFFF;
            bt[kk].be[b[1:0]]        = 1'b1;
            bt[kk].d[8*b[1:0] +: 8]  = d[8*i +: 8];
        end
        for (int k = 0; k < nb; k++) sb.push_back(bt[k]);
        push(a, sz, d);
    endtask

    // One clock: drive inputs at negedge, then inspect DUT state.
    task automatic step();
        beat_t e;
        @(negedge clk);
        rst      = rst_nx;
        drain_en = drain_nx;
        if (pop_pend) begin
            if (fq.size() > 0) fq.delete(0);
            pop_pend = 1'b0;
        end
        fifo_empty   = (fq.size() == 0);
        fifo_rd_data = fifo_empty ? '0 : fq[0];
        mem_ack      = force_ack || (mem_req && !rst && wait_cnt >= stall_n);
        #1;
        if (prev_pop) begin
            checks++;
            if (mem_req !== 1'b1) begin
                errors++; $display("FAIL pop_latency: mem_req=%b want 1", mem_req);
            end
        end
        if (prev_stall) begin
            checks++;
            if ({mem_addr, mem_wdata, mem_be} !== held) begin
                errors++;
                $display("FAIL stall_hold: got %h/%h/%b want %h/%h/%b",
                         mem_addr, mem_wdata, mem_be, held.a, held.d, held.be);
            end
        end
        prev_stall = mem_req && !mem_ack && !rst;
        held       = {mem_addr, mem_wdata, mem_be};
        if (mem_req === 1'b1 && drain_idle !== 1'b0) begin
            errors++; $display("FAIL idle_while_busy: drain_idle=%b want 0", drain_idle);
        end
        if (fifo_rd === 1'b1) begin
            checks++;
            if (fifo_empty) begin
                errors++; $display("FAIL rd_when_empty: fifo_rd=1 want 0");
            end
        end
        prev_pop = (fifo_rd === 1'b1) && !rst;
        if (prev_pop) begin pop_pend = 1'b1; pops++; end
        if (rst) begin
            wait_cnt = 0;
        end else if (mem_req && mem_ack) begin
            accepts++;
            if (fifo_rd) b2b++;
            checks++;
            if (sb.size() == 0) begin
                errors++; $display("FAIL unexpected_beat: got %h/%h/%b want none",
                                   mem_addr, mem_wdata, mem_be);
            end else begin
                e = sb.pop_front();
                if ({mem_addr, mem_wdata, mem_be} !== e) begin
                    errors++;
                    $display("FAIL beat: got %h/%h/%b want %h/%h/%b",
                             mem_addr, mem_wdata, mem_be, e.a, e.d, e.be);
                end
            end
            wait_cnt = 0;
        end else if (mem_req) begin
            wait_cnt++;
        end else begin
            wait_cnt = 0;
        end
    endtask

    task automatic run_until_done(input string name, input int budget);
        int n = 0;
        step();
        while (!(sb.size() == 0 && fq.size() == 0 && !pop_pend && mem_req === 1'b0) && n < budget) begin
            step(); n++;
        end
        checks++;
        if (n >= budget) begin
            errors++; $display("FAIL %s_timeout: pending beats=%0d want 0", name, sb.size());
        end
        checks++;
        if (drain_idle !== 1'b1) begin
            errors++; $display("FAIL %s_idle: drain_idle=%b want 1", name, drain_idle);
        end
    endtask

    task automatic test_reset();
        rst_nx = 1'b1;
        step(); step();
        checks++;
        if ({mem_req, mem_addr, mem_wdata, mem_be, fifo_rd, drain_idle} !== {1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs: req=%b addr=%h wd=%h be=%b rd=%b idle=%b want 0/0/0/0/0/1",
                     mem_req, mem_addr, mem_wdata, mem_be, fifo_rd, drain_idle);
        end
        push(32'h1000, 2'd2, 64'h1);
        step();
        checks++;
        if (drain_idle !== 1'b0 || fifo_rd !== 1'b0) begin
            errors++; $display("FAIL reset_follow: idle=%b rd=%b want 0/0", drain_idle, fifo_rd);
        end
        fq.delete();
        rst_nx = 1'b0;
        step();
    endtask

    task automatic test_idle_ack();
        int a0 = accepts;
        force_ack = 1'b1;
        repeat (3) step();
        force_ack = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || accepts != a0 || drain_idle !== 1'b1) begin
            errors++; $display("FAIL idle_ack: req=%b idle=%b want 0/1", mem_req, drain_idle);
        end
    endtask

    task automatic test_aligned();
        int p0 = pops, a0 = accepts;
        stall_n = 0;
        push(32'h0000_1000, 2'd2, 64'h0000_0000_DDCC_BBAA);
        exp_beat(32'h1000, 32'hDDCC_BBAA, 4'b1111);
        run_until_done("aligned", 50);
        checks++;
        if (pops - p0 != 1 || accepts - a0 != 1) begin
            errors++; $display("FAIL aligned_counts: pops=%0d beats=%0d want 1/1", pops - p0, accepts - a0);
        end
    endtask

    task automatic test_cross2();
        push(32'h0000_1003, 2'd1, 64'h2211);
        exp_beat(32'h1000, 32'h1100_0000, 4'b1000);
        exp_beat(32'h1004, 32'h0000_0022, 4'b0001);
        run_until_done("cross2", 50);
    endtask

    task automatic test_unaligned8();
        push(32'h0000_2001, 2'd3, 64'h8877_6655_4433_2211);
        exp_beat(32'h2000, 32'h3322_1100, 4'b1110);
        exp_beat(32'h2004, 32'h7766_5544, 4'b1111);
        exp_beat(32'h2008, 32'h0000_0088, 4'b0001);
        run_until_done("unaligned8", 50);
    endtask

    task automatic test_wrap();
        push(32'hFFFF_FFFE, 2'd2, 64'h4433_2211);
        exp_beat(32'hFFFF_FFFC, 32'h2211_0000, 4'b1100);
        exp_beat(32'h0000_0000, 32'h0000_4433, 4'b0011);
        run_until_done("wrap", 50);
    endtask

    task automatic test_stall();
        stall_n = 3;
        push(32'h0000_1003, 2'd1, 64'h2211);
        exp_beat(32'h1000, 32'h1100_0000, 4'b1000);
        exp_beat(32'h1004, 32'h0000_0022, 4'b0001);
        run_until_done("stall", 60);
        stall_n = 0;
    endtask

    task automatic test_back_to_back();
        int b0 = b2b, p0 = pops;
        push(32'h0000_3000, 2'd0, 64'hFFFF_FFFF_FFFF_FF5A);
        push(32'h0000_3005, 2'd0, 64'hFFFF_FFFF_FFFF_FFA5);
        exp_beat(32'h3000, 32'h0000_005A, 4'b0001);
        exp_beat(32'h3004, 32'h0000_A500, 4'b0010);
        run_until_done("b2b", 50);
        checks++;
        if (b2b - b0 != 1 || pops - p0 != 2) begin
            errors++; $display("FAIL b2b_pop: chained=%0d pops=%0d want 1/2", b2b - b0, pops - p0);
        end
    endtask

    task automatic test_drain_pause();
        int a0 = accepts, n = 0;
        stall_n = 1;
        push(32'h0000_2001, 2'd3, 64'h8877_6655_4433_2211);
        push(32'h0000_3000, 2'd0, 64'h5A);
        exp_beat(32'h2000, 32'h3322_1100, 4'b1110);
        exp_beat(32'h2004, 32'h7766_5544, 4'b1111);
        exp_beat(32'h2008, 32'h0000_0088, 4'b0001);
        exp_beat(32'h3000, 32'h0000_005A, 4'b0001);
        while (accepts - a0 < 1 && n < 30) begin step(); n++; end
        drain_nx = 1'b0;
        n = 0;
        step();
        while (mem_req === 1'b1 && n < 30) begin step(); n++; end
        repeat (4) step();
        checks++;
        if (sb.size() != 1 || fq.size() != 1 || mem_req !== 1'b0 || drain_idle !== 1'b0) begin
            errors++;
            $display("FAIL drain_pause: left=%0d fifo=%0d req=%b idle=%b want 1/1/0/0",
                     sb.size(), fq.size(), mem_req, drain_idle);
        end
        drain_nx = 1'b1;
        run_until_done("drain_resume", 50);
        stall_n = 0;
    endtask

    task automatic test_reset_midop();
        int a0 = accepts, n = 0, a1;
        bit bad = 1'b0;
        stall_n = 2;
        push(32'h0000_2001, 2'd3, 64'h8877_6655_4433_2211);
        exp_beat(32'h2000, 32'h3322_1100, 4'b1110);
        exp_beat(32'h2004, 32'h7766_5544, 4'b1111);
        exp_beat(32'h2008, 32'h0000_0088, 4'b0001);
        step();
        while (!(accepts - a0 == 1 && mem_req === 1'b1) && n < 30) begin step(); n++; end
        checks++;
        if (n >= 30) begin
            errors++; $display("FAIL midop_reach: beats=%0d want 1", accepts - a0);
        end
        rst_nx = 1'b1;
        step();
        rst_nx = 1'b0;
        sb.delete(); fq.delete(); pop_pend = 1'b0;
        step();
        checks++;
        if ({mem_req, mem_addr, mem_wdata, mem_be, drain_idle} !== {1'b0, 32'h0, 32'h0, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL midop_reset: req=%b addr=%h wd=%h be=%b idle=%b want 0/0/0/0/1",
                     mem_req, mem_addr, mem_wdata, mem_be, drain_idle);
        end
        a1 = accepts;
        repeat (5) begin step(); if (mem_req !== 1'b0) bad = 1'b1; end
        checks++;
        if (bad || accepts != a1) begin
            errors++; $display("FAIL midop_quiet: req seen=%b want 0", bad);
        end
        stall_n = 0;
    endtask

    task automatic test_random();
        for (int r = 0; r < 2; r++) begin
            stall_n = r * 2;
            for (int i = 0; i < 12; i++)
                model_push($urandom, 2'($urandom_range(0, 3)), {$urandom, $urandom});
            run_until_done("random", 400);
        end
        stall_n = 0;
    endtask

    initial begin
        checks = 0; errors = 0; stall_n = 0; wait_cnt = 0;
        pops = 0; accepts = 0; b2b = 0;
        force_ack = 1'b0; pop_pend = 1'b0; prev_pop = 1'b0; prev_stall = 1'b0;
        rst = 1'b1; drain_en = 1'b0; fifo_empty = 1'b1; fifo_rd_data = '0; mem_ack = 1'b0;
        rst_nx = 1'b1; drain_nx = 1'b1;
        test_reset();
        test_idle_ack();
        test_aligned();
        test_cross2();
        test_unaligned8();
        test_wrap();
        test_stall();
        test_back_to_back();
        test_drain_pause();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_drain_ctrl.md
Name: wb_drain_ctrl

Overview:
- Read-side consumer of the writeback store FIFO.
- Pops one store entry at a time and turns it into one or more aligned 32-bit memory-bus write beats with byte enables.
- Each beat completes under a req/ack handshake. Unaligned stores that cross word boundaries are split into up to 3 beats.
- Sits between the writeback-stage FIFO and the data-memory write port. Also reports when all pending stores have drained, which serializing instructions use.

Parameters:
- DATA_W, 98, FIFO entry width: {data[63:0], addr[31:0], size[1:0]}. Only 98 is supported.
- ADDR_W, 32, memory byte-address width.
- BUS_W, 32, memory data-bus width. Fixed at 32; byte enables are BUS_W/8 = 4 bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- fifo_empty  in  1  FIFO has no valid entry
- fifo_rd_data  in  DATA_W  head entry; valid combinationally while fifo_empty=0
- fifo_rd  out  1  pop pulse; FIFO advances its read pointer at this clock edge
- drain_en  in  1  permits popping new entries; an in-flight entry always completes
- mem_req  out  1  write beat valid
- mem_addr  out  32  word-aligned beat address; bits [1:0] are always 0
- mem_wdata  out  32  beat write data; disabled lanes driven to 0
- mem_be  out  4  byte-lane enables; bit j enables byte lane j (bits [8j+7:8j])
- mem_ack  in  1  beat accepted at this edge when mem_req=1
- drain_idle  out  1  1 when FSM is IDLE and fifo_empty=1

Behaviour:
- Entry fields:
  - data = fifo_rd_data[97:34]
  - addr = [33:2]
  - size = [1:0], with 0=1B, 1=2B, 2=4B, 3=8B
  - n = 1<<size bytes; only data[8n-1:0] is meaningful.
- FSM states: IDLE, BUSY.
- Reset:
  - state=IDLE, beat index=0.
  - mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, fifo_rd=0.
  - drain_idle follows fifo_empty.
- Pop rule:
  - In IDLE with fifo_empty=0 and drain_en=1: fifo_rd=1 combinationally for exactly that cycle.
  - Entry latched into local registers; go to BUSY.
  - First mem_req appears the next cycle. Pop-to-request latency is 1 cycle.
  - fifo_rd is never asserted when fifo_empty=1.
- Beat generation, on the latched entry:
  - off = addr[1:0]; span = off+n; beats = ceil(span/4), range 1..3.
  - A 96-bit window = zero-extended data shifted left by 8*off.
  - Beat k (k = 0..beats-1):
    - mem_addr = {addr[31:2]+k, 2'b00}, 30-bit add with wrap-around, no carry out.
    - mem_wdata = window[32k+31:32k].
    - mem_be[j] = 1 iff off ≤ 4k+j ≤ off+n-1.
- Handshake:
  - mem_req, mem_addr, mem_wdata and mem_be are registered and held stable until an edge with mem_ack=1.
  - Ack in the first cycle of req is legal.
  - mem_ack while mem_req=0 is ignored.
- After the ack of a non-last beat: the next beat is presented in the following cycle (k+1).
- After the ack of the last beat:
  - If fifo_empty=0 and drain_en=1: pop the next entry in that same cycle and stay BUSY. The next request follows with no bubble beyond the 1-cycle latency.
  - Otherwise: go to IDLE, mem_req=0.
- drain_en deasserted mid-entry: remaining beats still issue; no further pops.
- drain_idle is 0 throughout BUSY, including the cycle in which the last beat is acked.
- Reset mid-operation:
  - All outputs return to reset values next edge.
  - The partially written entry is abandoned; the FIFO is reset by the same rst.

Decomposition:
- Shared package:
  - Entry field positions (DATA_LO=34, ADDR_LO=2, SIZE_LO=0).
  - Size encodings SZ_1B..SZ_8B.
  - State encodings ST_IDLE/ST_BUSY.
- Sub-module wb_beat_gen (combinational):
  - Inputs: addr, size, data, beat index.
  - Outputs: mem_addr, mem_wdata, mem_be, last_beat.
  - The controller registers its outputs.

Test Plan:
- Aligned 4B: addr=0x00001000, size=2, data=0xDDCCBBAA, ack immediate → one beat: addr 0x1000, be 4'b1111, wdata 0xDDCCBBAA; fifo_rd pulsed once; drain_idle returns to 1.
- Crossing 2B: addr=0x00001003, size=1, data=0x2211 → beat0: 0x1000, be 4'b1000, wdata 0x11000000. Beat1: 0x1004, be 4'b0001, wdata 0x00000022.
- Unaligned 8B: addr=0x00002001, size=3, data=0x8877665544332211 → three beats:
  - 0x2000 / 4'b1110 / 0x33221100
  - 0x2004 / 4'b1111 / 0x77665544
  - 0x2008 / 4'b0001 / 0x00000088
- Address wrap: addr=0xFFFFFFFE, size=2, data=0x44332211 → beat0: 0xFFFFFFFC, be 4'b1100, wdata 0x22110000. Beat1: 0x00000000, be 4'b0011, wdata 0x00004433.
- Stall and back-to-back:
  - mem_ack held 0 for 3 cycles → addr/wdata/be unchanged across all 4 cycles.
  - Two 1B entries queued → second fifo_rd in the same cycle as the first entry's last ack; drain_en=0 mid-entry finishes the entry, then IDLE with no pop.
- Reset mid-op: rst=1 during beat1 of a 3-beat store → next edge mem_req=0, be=0, state IDLE, no further beats after rst falls until a new entry is popped.
